// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared pipeline widths, payload field indices and Tnew helper.
package cpu_pipe_pkg;

    localparam int DEF_TNEW_W = 2;
    localparam int DEF_ADDR_W = 5;

    localparam int FLD_INSTR = 0;
    localparam int FLD_RT    = 1;
    localparam int FLD_ALU   = 2;
    localparam int FLD_EXT   = 3;
    localparam int FLD_PC8   = 4;
    localparam int FLD_AUX   = 5;

    // Callers truncate the result back to their own Tnew width.
    function automatic logic [31:0] sat_dec(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset || clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with stall, flush, valid,
// Tnew tracking and a consecutive-stall counter.
module pipe_stage_reg #(
    parameter int NUM_FIELDS       = 6,
    parameter int FIELD_W          = 32,
    parameter int ADDR_W           = cpu_pipe_pkg::DEF_ADDR_W,
    parameter int TNEW_W           = cpu_pipe_pkg::DEF_TNEW_W,
    parameter bit DECR_ON_STALL    = 1'b0,
    parameter bit KEEP_PC_ON_FLUSH = 1'b1,
    parameter int CNT_W            = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    input  logic [ADDR_W-1:0]             in_wba,
    input  logic [TNEW_W-1:0]             in_tnew,
    input  logic [31:0]                   in_pc,
    output logic                          out_valid,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    output logic [ADDR_W-1:0]             out_wba,
    output logic [TNEW_W-1:0]             out_tnew,
    output logic [31:0]                   out_pc,
    output logic [CNT_W-1:0]              stall_cnt
);

    import cpu_pipe_pkg::*;

    logic [TNEW_W-1:0] in_tnew_dec, out_tnew_dec;

    assign in_tnew_dec  = TNEW_W'(sat_dec(32'(in_tnew)));
    assign out_tnew_dec = TNEW_W'(sat_dec(32'(out_tnew)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wba   <= '0;
            out_tnew  <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_wba   <= '0;
            out_tnew  <= '0;
            out_pc    <= KEEP_PC_ON_FLUSH ? in_pc : 32'd0;
        end else if (stall) begin
            if (DECR_ON_STALL)
                out_tnew <= out_tnew_dec;
        end else begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_pc    <= in_pc;
            // Bubbles never advertise a destination, so forwarding needs no valid check.
            out_wba   <= in_valid ? in_wba : '0;
            out_tnew  <= in_valid ? in_tnew_dec : '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clr   (flush || !stall),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for two pipe_stage_reg configurations
// sharing one stimulus stream.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic         valid;
        logic [191:0] data;
        logic [4:0]   wba;
        logic [1:0]   tnew;
        logic [31:0]  pc;
        logic [7:0]   cnt;
    } st_t;

    logic         clk = 1'b0;
    logic         reset, stall, flush, in_valid;
    logic [191:0] in_data;
    logic [4:0]   in_wba;
    logic [1:0]   in_tnew;
    logic [31:0]  in_pc;

    logic         v0, v1;
    logic [191:0] d0, d1;
    logic [4:0]   w0, w1;
    logic [1:0]   t0, t1;
    logic [31:0]  p0, p1;
    logic [7:0]   c0, c1;

    int   checks = 0;
    int   passed = 0;
    st_t  m0 = '0, m1 = '0;
    st_t  q0[$], q1[$];

    always #5 clk = ~clk;

    pipe_stage_reg dut0 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_wba(in_wba),
        .in_tnew(in_tnew), .in_pc(in_pc),
        .out_valid(v0), .out_data(d0), .out_wba(w0), .out_tnew(t0),
        .out_pc(p0), .stall_cnt(c0)
    );

    pipe_stage_reg #(.DECR_ON_STALL(1'b1), .KEEP_PC_ON_FLUSH(1'b0)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_wba(in_wba),
        .in_tnew(in_tnew), .in_pc(in_pc),
        .out_valid(v1), .out_data(d1), .out_wba(w1), .out_tnew(t1),
        .out_pc(p1), .stall_cnt(c1)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            passed++;
    endtask

    function automatic st_t model(input st_t s, input bit decr, input bit keep);
        st_t n;
        n = s;
        if (!reset) begin
            n = '0;
        end else if (flush) begin
            n = '0;
            n.pc = keep ? in_pc : 32'd0;
        end else if (stall) begin
            if (decr && s.tnew != 2'd0)
                n.tnew = s.tnew - 2'd1;
            if (s.cnt != 8'hff)
                n.cnt = s.cnt + 8'd1;
        end else begin
            n.valid = in_valid;
            n.data  = in_data;
            n.pc    = in_pc;
            n.wba   = in_valid ? in_wba : 5'd0;
            n.tnew  = (in_valid && in_tnew != 2'd0) ? in_tnew - 2'd1 : 2'd0;
            n.cnt   = 8'd0;
        end
        return n;
    endfunction

    task automatic cmp(input string p, input st_t g, input st_t e);
        check({p, ".valid"}, 256'(g.valid), 256'(e.valid));
        check({p, ".data"},  256'(g.data),  256'(e.data));
        check({p, ".wba"},   256'(g.wba),   256'(e.wba));
        check({p, ".tnew"},  256'(g.tnew),  256'(e.tnew));
        check({p, ".pc"},    256'(g.pc),    256'(e.pc));
        check({p, ".cnt"},   256'(g.cnt),   256'(e.cnt));
    endtask

    // Expected results are queued at drive time and retired after the edge.
    task automatic step();
        st_t e;
        m0 = model(m0, 1'b0, 1'b1);
        m1 = model(m1, 1'b1, 1'b0);
        q0.push_back(m0);
        q1.push_back(m1);
        @(posedge clk);
        #1;
        e = q0.pop_front();
        cmp("dut0", {v0, d0, w0, t0, p0, c0}, e);
        e = q1.pop_front();
        cmp("dut1", {v1, d1, w1, t1, p1, c1}, e);
    endtask

    task automatic drive(input logic rs, input logic st, input logic fl, input logic iv,
                         input logic [4:0] wba, input logic [1:0] tn, input logic [31:0] pc);
        reset = rs; stall = st; flush = fl; in_valid = iv;
        in_wba = wba; in_tnew = tn; in_pc = pc;
        for (int k = 0; k < 6; k++)
            in_data[k*32 +: 32] = $urandom;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 2'd3, 32'h1234);
        step();
        step();
        check("rst.valid", 256'(v0), 256'(0));
        check("rst.cnt", 256'(c0), 256'(0));

        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 2'd2, 32'h3000);
        in_data[31:0] = 32'h8C820004;
        step();
        check("load.valid", 256'(v0), 256'(1));
        check("load.wba", 256'(w0), 256'(5));
        check("load.tnew", 256'(t0), 256'(1));
        check("load.f0", 256'(d0[31:0]), 256'(32'h8C820004));

        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 2'd3, 32'h3004);
        step();
        check("t3.tnew", 256'(t1), 256'(2));
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 5'(i + 10), 2'd1, 32'h4000 + 32'(i));
            step();
            check("stall.cnt", 256'(c0), 256'(i));
            check("stall.wba", 256'(w0), 256'(9));
            check("stall.tnew0", 256'(t0), 256'(2));
            check("stall.tnew1", 256'(t1), 256'(i == 1 ? 1 : 0));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 2'd2, 32'h3008);
        step();
        check("rel.cnt", 256'(c0), 256'(0));
        check("rel.wba", 256'(w0), 256'(20));

        drive(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 2'd2, 32'h00003010);
        step();
        check("flush.valid", 256'(v0), 256'(0));
        check("flush.pc0", 256'(p0), 256'(32'h00003010));
        check("flush.pc1", 256'(p1), 256'(0));
        check("flush.cnt", 256'(c0), 256'(0));

        drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 2'd3, 32'h300C);
        step();
        check("inv.wba", 256'(w0), 256'(0));
        check("inv.tnew", 256'(t0), 256'(0));

        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 2'd0, 32'h3010);
        step();
        check("t0.tnew", 256'(t0), 256'(0));
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 2'd2, 32'h5000);
        for (int i = 0; i < 300; i++)
            step();
        check("sat.cnt", 256'(c0), 256'(255));

        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 2'd2, 32'h6000);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 2'd1, 32'h6004);
        step();
        step();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 2'd1, 32'h6008);
        step();
        check("mrst.valid", 256'(v0), 256'(0));
        check("mrst.pc", 256'(p0), 256'(0));
        check("mrst.cnt", 256'(c0), 256'(0));
        drive(1'b1, 1'b1, 1'b0, 1'b1, 5'd2, 2'd1, 32'h600C);
        step();
        check("post.cnt", 256'(c0), 256'(1));
        check("post.wba", 256'(w0), 256'(0));
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 2'd3, 32'h6010);
        step();
        check("post.load", 256'(w0), 256'(12));

        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), 1'($urandom), 5'($urandom),
                  2'($urandom), $urandom);
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined MIPS CPU. It replaces the fixed per-boundary registers (D/E, E/M, M/W) with one block. The block adds stall (hold), flush (bubble insertion), a valid bit, Tnew hazard-timing tracking and a consecutive-stall counter. The hazard unit drives `stall`/`flush`, and forwarding logic reads `out_wba`/`out_tnew`.

## Interface
- `NUM_FIELDS`, 6: number of 32-bit-class payload fields (Instr, RT, ALU, EXT, PC8, …).
- `FIELD_W`, 32: width of each payload field.
- `ADDR_W`, 5: write-back register address width.
- `TNEW_W`, 2: Tnew field width.
- `DECR_ON_STALL`, 0: 1 = `out_tnew` also decrements while held by stall.
- `KEEP_PC_ON_FLUSH`, 1: 1 = `out_pc` retains incoming PC on flush (EPC support); 0 = clears to 0.
- `CNT_W`, 8: stall counter width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets all state.
- `stall` in 1: hold current contents.
- `flush` in 1: load a bubble.
- `in_valid` in 1: incoming instruction valid.
- `in_data` in `NUM_FIELDS*FIELD_W`: packed payload, field k at bits [k*FIELD_W +: FIELD_W].
- `in_wba` in `ADDR_W`: destination register; 0 = no write.
- `in_tnew` in `TNEW_W`: cycles until result is available, measured at the upstream stage.
- `in_pc` in 32: PC of the incoming instruction.
- `out_valid` out 1, `out_data` out `NUM_FIELDS*FIELD_W`, `out_wba` out `ADDR_W`, `out_tnew` out `TNEW_W`, `out_pc` out 32: registered stage contents.
- `stall_cnt` out `CNT_W`: consecutive cycles held by stall.

## Operation
- Per-edge priority: reset > flush > stall > load.
- Reset (`reset`=0): all outputs 0, including `stall_cnt`.
- Flush:
  - `out_valid`=0, `out_data`=0, `out_wba`=0, `out_tnew`=0.
  - `out_pc` = `in_pc` if `KEEP_PC_ON_FLUSH`, else 0.
  - `stall_cnt`=0.
  - Flush with stall asserted: flush wins.
- Stall (flush=0):
  - data, wba, pc and valid hold.
  - `out_tnew` = sat_dec(`out_tnew`) if `DECR_ON_STALL`, else hold.
  - `stall_cnt` increments, saturating at 2^CNT_W−1.
- Load (flush=0, stall=0):
  - `out_valid`=`in_valid`; `out_data`=`in_data`; `out_pc`=`in_pc`.
  - `out_wba` = `in_valid` ? `in_wba` : 0.
  - `out_tnew` = `in_valid` ? sat_dec(`in_tnew`) : 0.
  - `stall_cnt`=0.
- sat_dec(x) = (x==0) ? 0 : x−1, computed at `TNEW_W` width; it never wraps.
- Invalid entries never expose a nonzero `out_wba`, so forwarding logic needs no valid qualification.
- Payload is opaque; no field is interpreted.

## Timing
- Latency: 1 cycle from inputs to outputs on load. Outputs are purely registered, with no combinational input-to-output path.
- Stall of N cycles holds payload for N edges; the first unstalled edge loads the input.
- `stall_cnt` reads 1 after the first stalled edge and k after k consecutive stalled edges. It clears on the edge of any load or flush.
- Reset deasserting mid-stall: the first edge with `reset`=1 follows normal priority from the zeroed state. A stall there holds zeros and `stall_cnt` becomes 1.
- `in_tnew`=0 loads `out_tnew`=0 (saturation boundary).
- `in_tnew`=3 (with `TNEW_W`=2) loads `out_tnew`=2.

## Structure
- Shared package `cpu_pipe_pkg`:
  - `TNEW_W`, `ADDR_W` defaults.
  - field index constants (FLD_INSTR=0, FLD_RT=1, FLD_ALU=2, FLD_EXT=3, FLD_PC8=4, FLD_AUX=5).
  - sat_dec function.
- One natural sub-module: `sat_counter` (parametrised width, inc/clr, saturating). It is used for `stall_cnt` and reusable by the hazard unit's performance counters.
- Instantiate once per stage boundary, with `NUM_FIELDS` sized per boundary.

## Test plan
- Reset, then load `in_valid`=1, `in_wba`=5, `in_tnew`=2, field0=0x8C820004 → next cycle `out_valid`=1, `out_wba`=5, `out_tnew`=1, field0=0x8C820004.
- Hold `stall`=1 for 3 edges with new inputs applied → outputs unchanged, `stall_cnt`=1,2,3. Release → new input loaded, `stall_cnt`=0. Repeat with `DECR_ON_STALL`=1 and `out_tnew`=2 → 1, 0, 0.
- `flush`=1 and `stall`=1 together with `in_pc`=0x00003010 → `out_valid`=0, `out_wba`=0, `out_tnew`=0, `out_pc`=0x00003010. With `KEEP_PC_ON_FLUSH`=0, `out_pc`=0.
- Load `in_valid`=0, `in_wba`=31, `in_tnew`=3 → `out_wba`=0, `out_tnew`=0, `out_valid`=0.
- Stall for 300 edges with `CNT_W`=8 → `stall_cnt` saturates at 255 with no wrap.
- Assert `reset`=0 mid-stall with valid contents → all outputs 0 on that edge. `reset`=1 with no stall → the next input loads normally.
